// File: rtl/derandomizer_rx.sv
// derandomizer_rx
// Receive-side PRBS derandomizer (x^15 + x^14 + 1). Each accepted input bit is
// XORed with the same keystream the transmitter applied. The keystream restarts
// from the seed register on every start-of-frame. A small framing FSM tracks
// frame boundaries, truncates over-long frames and flags framing errors.
// Surviving beats leave through a 2-entry skid buffer so that downstream
// back-pressure never corrupts the output.

module derandomizer_rx #(
  parameter logic [14:0] SEED    = 15'b100101010000000,
  parameter int          MAX_LEN = 2048,
  parameter int          LEN_W   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_ld,
  input  logic [14:0] seed_val,
  input  logic        bypass,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_data,
  input  logic        s_sof,
  input  logic        s_eof,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_data,
  output logic        m_sof,
  output logic        m_eof,
  output logic        err_nosof,
  output logic        err_sof,
  output logic        err_len
);

  // Beat number at which a frame without eof is forcibly terminated.
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  count_nxt;
  logic [LEN_W-1:0]  beat_num;
  logic [14:0]       lfsr;
  logic [14:0]       lfsr_nxt;
  logic [14:0]       seed_reg;
  logic [14:0]       key_src;
  logic              key;
  logic              accept;
  logic              forced_eof;

  logic              beat_keep;
  logic              beat_data;
  logic              beat_sof;
  logic              beat_eof;
  logic              nosof_nxt;
  logic              sof_err_nxt;
  logic              len_err_nxt;

  logic [2:0]        beat_ent;
  logic [2:0]        ent0;
  logic [2:0]        ent1;
  logic [2:0]        ent0_nxt;
  logic [2:0]        ent1_nxt;
  logic [1:0]        occ;
  logic [1:0]        occ_nxt;
  logic              pop;

  assign accept = s_valid & s_ready;

  // Framing and keystream: decide whether the accepted beat is kept, what it
  // decodes to, and how the LFSR, frame state and beat counter move on.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    lfsr_nxt    = lfsr;
    beat_num    = count + LEN_W'(1);
    key_src     = lfsr;
    key         = 1'b0;
    forced_eof  = 1'b0;
    beat_keep   = 1'b0;
    beat_data   = s_data;
    beat_sof    = s_sof;
    beat_eof    = s_eof;
    nosof_nxt   = 1'b0;
    sof_err_nxt = 1'b0;
    len_err_nxt = 1'b0;

    if (accept) begin
      if ((state == IDLE) && !s_sof) begin
        nosof_nxt = 1'b1;
      end else begin
        beat_keep = 1'b1;
        if (s_sof) begin
          key_src  = seed_reg;
          beat_num = LEN_W'(1);
          if (state == RUN) begin
            sof_err_nxt = 1'b1;
          end
        end
        key = key_src[0] ^ key_src[1];
        if (!bypass) begin
          beat_data = s_data ^ key;
          lfsr_nxt  = {key, key_src[14:1]};
        end
        forced_eof  = !s_eof && (beat_num == MAX_CNT);
        beat_eof    = s_eof | forced_eof;
        len_err_nxt = forced_eof;
        if (beat_eof) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          state_nxt = RUN;
          count_nxt = beat_num;
        end
      end
    end
  end

  // Frame state, beat counter, keystream register and seed register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      lfsr     <= SEED;
      seed_reg <= SEED;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      lfsr  <= lfsr_nxt;
      if (seed_ld) begin
        seed_reg <= seed_val;
      end
    end
  end

  // Error pulses land one cycle after the offending beat was accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_nosof <= 1'b0;
      err_sof   <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_nosof <= nosof_nxt;
      err_sof   <= sof_err_nxt;
      err_len   <= len_err_nxt;
    end
  end

  assign beat_ent = {beat_data, beat_sof, beat_eof};
  assign pop      = (occ != 2'd0) & m_ready;

  // Skid buffer bookkeeping: entry 0 is always the head presented on m_*.
  // A push into a full buffer cannot happen because s_ready is low then.
  always_comb begin
    ent0_nxt = ent0;
    ent1_nxt = ent1;
    occ_nxt  = occ;
    case ({beat_keep, pop})
      2'b10: begin
        if (occ == 2'd0) begin
          ent0_nxt = beat_ent;
        end else begin
          ent1_nxt = beat_ent;
        end
        occ_nxt = occ + 2'd1;
      end
      2'b01: begin
        ent0_nxt = ent1;
        occ_nxt  = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          ent0_nxt = beat_ent;
        end else begin
          ent0_nxt = ent1;
          ent1_nxt = beat_ent;
        end
      end
      default: begin
      end
    endcase
  end

  // Skid storage plus a registered s_ready that is low during reset and
  // whenever both entries will be occupied next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent0    <= '0;
      ent1    <= '0;
      occ     <= 2'd0;
      s_ready <= 1'b0;
    end else begin
      ent0    <= ent0_nxt;
      ent1    <= ent1_nxt;
      occ     <= occ_nxt;
      s_ready <= (occ_nxt < 2'd2);
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid & ent0[2];
  assign m_sof   = m_valid & ent0[1];
  assign m_eof   = m_valid & ent0[0];

endmodule

// File: tb/tb_derandomizer_rx.sv
// tb_derandomizer_rx
// Scoreboard bench for derandomizer_rx. Stimulus pushes the expected output
// beat into a queue; monitors pop and compare whenever a beat leaves a DUT.
// A second instance with MAX_LEN=8 exercises frame truncation.

module tb_derandomizer_rx;

  localparam logic [14:0] SEED_DEF = 15'b100101010000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        seed_ld = 1'b0;
  logic [14:0] seed_val = '0;
  logic        bypass = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_valid2 = 1'b0;
  logic        s_data = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_eof = 1'b0;
  logic        m_ready = 1'b1;

  logic s_ready, m_valid, m_data, m_sof, m_eof, err_nosof, err_sof, err_len;
  logic s_ready2, m_valid2, m_data2, m_sof2, m_eof2, err_nosof2, err_sof2, err_len2;

  int checks = 0;
  int errors = 0;
  int n_nosof = 0, n_sof = 0, n_len = 0;
  int n_nosof2 = 0, n_sof2 = 0, n_len2 = 0;
  bit rand_ready = 1'b0;
  bit chk_ready = 1'b0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_q2[$];
  logic [2:0] exp_e, exp_e2;

  // Keystream for SEED_DEF, beat 0 in bit 0.
  logic [13:0] t1_exp = 14'b10_1111_1100_0000;

  derandomizer_rx dut (
    .clk(clk), .reset(reset), .seed_ld(seed_ld), .seed_val(seed_val), .bypass(bypass),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof),
    .err_nosof(err_nosof), .err_sof(err_sof), .err_len(err_len)
  );

  derandomizer_rx #(.SEED(SEED_DEF), .MAX_LEN(8), .LEN_W(4)) dut_short (
    .clk(clk), .reset(reset), .seed_ld(seed_ld), .seed_val(seed_val), .bypass(bypass),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_sof(m_sof2), .m_eof(m_eof2),
    .err_nosof(err_nosof2), .err_sof(err_sof2), .err_len(err_len2)
  );

  always #5 clk = ~clk;

  // Random downstream back-pressure, changed just after each rising edge.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Main-instance monitor: every transferred beat must match the queue head.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out: got beat %b required none", {m_data, m_sof, m_eof});
      end else begin
        exp_e = exp_q.pop_front();
        check_output("out_beat", {29'd0, m_data, m_sof, m_eof}, {29'd0, exp_e});
      end
    end
    if (reset && chk_ready && !s_ready) begin
      check_output("ready_low_means_full", {31'd0, m_valid}, 32'd1);
    end
    if (err_nosof) n_nosof++;
    if (err_sof) n_sof++;
    if (err_len) n_len++;
  end

  // Short-frame instance monitor.
  always @(negedge clk) begin
    if (reset && m_valid2 && m_ready) begin
      if (exp_q2.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out2: got beat %b required none", {m_data2, m_sof2, m_eof2});
      end else begin
        exp_e2 = exp_q2.pop_front();
        check_output("out_beat2", {29'd0, m_data2, m_sof2, m_eof2}, {29'd0, exp_e2});
      end
    end
    if (err_nosof2) n_nosof2++;
    if (err_sof2) n_sof2++;
    if (err_len2) n_len2++;
  end

  // Present one beat at a falling edge and hold it until it has been accepted.
  task automatic apply_stimulus(input bit sel, input logic d, input logic sof, input logic eof);
    int g;
    g = 0;
    s_data = d;
    s_sof  = sof;
    s_eof  = eof;
    if (sel) s_valid2 = 1'b1;
    else     s_valid  = 1'b1;
    while (((sel ? s_ready2 : s_ready) == 1'b0) && (g < 200)) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got s_ready 0 required 1");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (((exp_q.size() != 0) || (exp_q2.size() != 0)) && (g < 3000)) begin
      @(negedge clk);
      g++;
    end
    check_output("drain", exp_q.size() + exp_q2.size(), 0);
  endtask

  // Transmit-side randomizer model: expected output is the original bit.
  task automatic round_trip(input logic [14:0] seed, input int n, input int ld_at, input bit gaps);
    logic [14:0] tx;
    logic orig, k;
    tx = seed;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
      orig = 1'($urandom_range(0, 1));
      k    = tx[0] ^ tx[1];
      tx   = {k, tx[14:1]};
      exp_q.push_back({orig, i == 0, i == n - 1});
      seed_ld  = (i == ld_at);
      seed_val = 15'h7FFF;
      apply_stimulus(1'b0, orig ^ k, i == 0, i == n - 1);
    end
    seed_ld = 1'b0;
  endtask

  task automatic load_seed(input logic [14:0] v);
    seed_val = v;
    seed_ld  = 1'b1;
    @(negedge clk);
    seed_ld  = 1'b0;
  endtask

  initial begin
    int base_a, base_b, base_c;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check_output("rst_outputs", {25'd0, m_valid, m_data, m_sof, m_eof, err_nosof, err_sof, err_len}, 32'd0);
    check_output("rst_outputs2", {31'd0, m_valid2}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_output("ready_after_release", {31'd0, s_ready}, 32'd1);

    // T1: all-zero frame with the default seed shows the raw keystream
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back({t1_exp[i], i == 0, i == 13});
      apply_stimulus(1'b0, 1'b0, i == 0, i == 13);
    end
    idle(2);

    // T2: round trip with default seed, seed_ld mid-frame, then seed 7FFF
    round_trip(SEED_DEF, 500, 100, 1'b0);
    idle(2);
    round_trip(15'h7FFF, 500, -1, 1'b0);
    idle(2);
    wait_drain();

    // T3: random back-pressure and random input gaps
    rand_ready = 1'b1;
    chk_ready  = 1'b1;
    round_trip(15'h7FFF, 200, -1, 1'b1);
    idle(1);
    wait_drain();
    chk_ready  = 1'b0;
    rand_ready = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    load_seed(SEED_DEF);

    // T4: beats without sof in IDLE are dropped, one err_nosof each
    base_a = n_nosof;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    check_output("t4_nosof_count", n_nosof - base_a, 3);

    // Bypass mid-frame: data passes unchanged, keystream does not advance
    for (int i = 0; i < 10; i++) begin
      bypass = (i == 2) || (i == 3);
      exp_q.push_back({(bypass ? 1'b1 : (i < 2 ? t1_exp[i] : t1_exp[i - 2])), i == 0, i == 9});
      apply_stimulus(1'b0, bypass, i == 0, i == 9);
    end
    bypass = 1'b0;
    idle(2);

    // T5: sof at beat 5 of a running frame reseeds and flags err_sof
    base_a = n_sof;
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back({(i < 5 ? t1_exp[i] : t1_exp[i - 5]), (i == 0) || (i == 5), i == 12});
      apply_stimulus(1'b0, 1'b0, (i == 0) || (i == 5), i == 12);
    end
    idle(3);
    check_output("t5_sof_err_count", n_sof - base_a, 1);
    wait_drain();

    // T6: MAX_LEN=8 instance, 10-beat frame is cut at beat 7
    base_a = n_nosof2;
    base_b = n_len2;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q2.push_back({t1_exp[i], i == 0, i == 7});
      apply_stimulus(1'b1, 1'b0, i == 0, i == 9);
    end
    idle(3);
    check_output("t6_len_err_count", n_len2 - base_b, 1);
    check_output("t6_nosof_count", n_nosof2 - base_a, 2);
    wait_drain();

    // T6: async reset mid-frame with a full skid buffer
    load_seed(15'h7FFF);
    m_ready = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check_output("skid_one_ready", {31'd0, s_ready2}, 32'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("skid_full_ready", {31'd0, s_ready2}, 32'd0);
    check_output("skid_full_valid", {31'd0, m_valid2}, 32'd1);
    s_valid2 = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("midreset_valid", {31'd0, m_valid2}, 32'd0);
    check_output("midreset_ready", {31'd0, s_ready2}, 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    base_c = n_len2;
    for (int i = 0; i < 8; i++) begin
      exp_q2.push_back({t1_exp[i], i == 0, i == 7});
      apply_stimulus(1'b1, 1'b0, i == 0, i == 7);
    end
    idle(3);
    check_output("post_reset_len_err", n_len2 - base_c, 0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
